// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives a 1-bit ALU slice LSB-first over WIDTH cycles
// and returns the full-width result with zero/carry/overflow flags.
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ainv_q, ainv_d, binv_q, binv_d, arith_q, arith_d, valid_q, valid_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             a_bit, b_bit, sum_bit, c_arith, r_bit, c_bit, ovf_bit, set_bit, accept;
  logic [WIDTH-1:0] res_shift, final_res;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      arith_q  <= 1'b0;
      valid_q  <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      ainv_q   <= ainv_d;
      binv_q   <= binv_d;
      arith_q  <= arith_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // The 1-bit slice, evaluated on the current LSB of the operand shift registers.
  always_comb begin
    a_bit   = a_q[0] ^ ainv_q;
    b_bit   = b_q[0] ^ binv_q;
    sum_bit = a_bit ^ b_bit ^ carry_q;
    c_arith = (a_bit & b_bit) | ((a_bit ^ b_bit) & carry_q);
    r_bit   = 1'b0;
    c_bit   = 1'b0;
    case (op_q)
      2'b00: r_bit = a_bit & b_bit;
      2'b01: r_bit = a_bit | b_bit;
      2'b10: begin r_bit = sum_bit; c_bit = c_arith; end
      default: begin r_bit = 1'b0; c_bit = c_arith; end
    endcase
    ovf_bit   = arith_q ? (carry_q ^ c_bit) : 1'b0;
    set_bit   = sum_bit ^ ovf_bit;
    res_shift = {r_bit, {(WIDTH-1){1'b0}}} | (res_q >> 1);
    if (!valid_q)
      final_res = '0;
    else if (op_q == 2'b11)
      final_res = {{(WIDTH-1){1'b0}}, set_bit};
    else
      final_res = res_shift;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    ainv_d   = ainv_q;
    binv_d   = binv_q;
    arith_d  = arith_q;
    valid_d  = valid_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;

    case (state_q)
      IDLE: accept = start_i;
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = c_bit;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH-1)) begin
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = valid_q & c_bit;
          ovf_d    = valid_q & ovf_bit;
          state_d  = DONE;
        end
      end
      DONE: begin
        accept  = start_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = src1_i;
      b_d     = src2_i;
      res_d   = '0;
      idx_d   = '0;
      state_d = RUN;
      ainv_d  = 1'b0;
      binv_d  = 1'b0;
      op_d    = 2'b00;
      carry_d = 1'b0;
      arith_d = 1'b0;
      valid_d = 1'b1;
      case (ctrl_i)
        4'b0000: op_d = 2'b00;
        4'b0001: op_d = 2'b01;
        4'b0010: begin op_d = 2'b10; arith_d = 1'b1; end
        4'b0110: begin op_d = 2'b10; binv_d = 1'b1; carry_d = 1'b1; arith_d = 1'b1; end
        4'b0111: begin op_d = 2'b11; binv_d = 1'b1; carry_d = 1'b1; arith_d = 1'b1; end
        4'b1100: begin ainv_d = 1'b1; binv_d = 1'b1; end
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Randomized and directed checks of serial_alu_ctrl against an arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int W = 32;

  logic         clk, rst, start;
  logic [3:0]   ctrl;
  logic [W-1:0] src1, src2;
  logic         busy, done, zero, cout, ovf;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .busy_o(busy), .done_o(done),
    .result_o(result), .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, zero, cout, overflow} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] res;
    logic         co, ov;
    res = '0; co = 1'b0; ov = 1'b0;
    case (c)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b);
      4'b0010: begin
        t   = {1'b0, a} + {1'b0, b};
        res = t[W-1:0];
        co  = t[W];
        ov  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      4'b0110, 4'b0111: begin
        t   = {1'b0, a} + {1'b0, ~b} + 1;
        co  = t[W];
        ov  = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        res = (c == 4'b0110) ? t[W-1:0] : (($signed(a) < $signed(b)) ? 1 : 0);
      end
      default: res = '0;
    endcase
    return {res, (res == '0), co, ov};
  endfunction

  // Caller must be at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W+2:0] got);
    ctrl = c; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ctrl = 4'($urandom); src1 = $urandom; src2 = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = {result, zero, cout, ovf};
    $display("op ctrl=%b a=%h b=%h -> result=%h z=%b c=%b v=%b lat=%0d", c, a, b, result, zero, cout, ovf, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
    #1;
    total++;
    if ({busy, done, result, zero, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, result, zero, cout, ovf});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_ovf();
    int lat; logic [W+2:0] got, exp;
    exp = model(4'b0010, 32'h7FFF_FFFF, 32'h1);
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL add_ovf got=%h want=%h", got, exp); end
    total++;
    if (lat !== W) begin bad++; $display("FAIL add_latency got=%0d want=%0d", lat, W); end
    @(negedge clk);
  endtask

  task automatic test_sub_b2b();
    int lat; logic [W+2:0] got, exp;
    exp = model(4'b0110, 32'd5, 32'd5);
    run_op(4'b0110, 32'd5, 32'd5, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL sub_zero got=%h want=%h", got, exp); end
    exp = model(4'b0010, 32'hFFFF_FFFF, 32'h1);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL b2b_add got=%h want=%h", got, exp); end
    total++;
    if (lat !== W) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, W); end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL done_pulse got=%b want=00", {done, busy}); end
  endtask

  task automatic test_slt();
    int lat; logic [W+2:0] got, exp;
    exp = model(4'b0111, 32'hFFFF_FFFF, 32'h1);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL slt_neg got=%h want=%h", got, exp); end
    exp = model(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL slt_ovf got=%h want=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_logic();
    logic [3:0]   codes [5] = '{4'b0000, 4'b0001, 4'b1100, 4'b1111, 4'b0011};
    logic [W-1:0] as    [5] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [W-1:0] bs    [5] = '{32'hFF00_FF00, 32'hFF00_FF00, 32'h0, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
    int lat; logic [W+2:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      exp = model(codes[i], as[i], bs[i]);
      run_op(codes[i], as[i], bs[i], lat, got);
      total++;
      if (got !== exp) begin bad++; $display("FAIL logic_%0d got=%h want=%h", i, got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [W+2:0] got = '0, exp;
    exp = model(4'b0010, 32'd3, 32'd4);
    ctrl = 4'b0010; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= W + 10; cyc++) begin
      start = (cyc == 5 || cyc == 10);
      ctrl = 4'b0000; src1 = $urandom; src2 = $urandom;
      @(negedge clk);
      if (done) begin ndone++; got = {result, zero, cout, ovf}; end
    end
    start = 1'b0;
    $display("ignore_start dones=%0d result=%h", ndone, got[W+2:3]);
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL ignore_result got=%h want=%h", got, exp); end
  endtask

  task automatic test_reset_abort();
    int lat, ndone = 0; logic [W+2:0] got, exp;
    ctrl = 4'b0010; src1 = 32'h0001_0000; src2 = 32'h0000_0FFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset_abort outputs=%h", {busy, done, result, zero, cout, ovf});
    total++;
    if ({busy, done, result, zero, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0", {busy, done, result, zero, cout, ovf});
    end
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst = 1'b0;
    repeat (W + 4) begin @(negedge clk); if (done) ndone++; end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    exp = model(4'b0010, 32'd3, 32'd4);
    run_op(4'b0010, 32'd3, 32'd4, lat, got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL after_reset_add got=%h want=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
    logic [W-1:0] a, b;
    logic [3:0] c;
    int lat; logic [W+2:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 6)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {~a[W-1], a[W-2:0]} | 32'h7FFF_FF00;
      exp = model(c, a, b);
      run_op(c, a, b, lat, got);
      total++;
      if (got !== exp || lat !== W) begin
        bad++;
        $display("FAIL random_%0d got=%h lat=%0d want=%h lat=%0d", i, got, lat, exp, W);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_b2b();
    test_slt();
    test_logic();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial 32-bit ALU sequencer. It drives the 1-bit ALU slice function (A_invert, B_invert, cin, operation, less) one bit per cycle, LSB first.
- It collects the per-bit result and carry, then returns a full-width result with flags.
- It is the initiator/controller side of the 1-bit slice interface. It gives a low-area alternative to the 32-slice ripple ALU in the single-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 2..64).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  request; sampled only while busy_o=0
- ctrl_i  input  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- src1_i  input  WIDTH  operand A
- src2_i  input  WIDTH  operand B
- busy_o  output  1  operation in progress
- done_o  output  1  single-cycle pulse; result/flags valid from this cycle
- result_o  output  WIDTH  result, held until next completion
- zero_o  output  1  result_o == 0
- cout_o  output  1  carry out of bit WIDTH-1
- overflow_o  output  1  signed overflow

Behaviour:
- Clock/reset: one clock clk_i. rst_i is asynchronous and active-high.
- On reset:
  - state=IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, cout_o=0, overflow_o=0.
  - Internal shift regs, bit index and carry flop cleared.
- Reset mid-operation aborts immediately. No done_o; outputs return to reset values.
- Decode on accept (latched, not re-read during RUN):
  - AND: Ainv=0, Binv=0, op=00
  - OR: Ainv=0, Binv=0, op=01
  - ADD: Ainv=0, Binv=0, op=10, cin0=0
  - SUB: Ainv=0, Binv=1, op=10, cin0=1
  - SLT: Ainv=0, Binv=1, op=11, cin0=1
  - NOR: Ainv=1, Binv=1, op=00
  - Any other code: result 0, cout 0, overflow 0, same latency.
- Per-bit function at bit i:
  - a=src1[i]^Ainv, b=src2[i]^Binv.
  - op00: r=a&b, c=0. op01: r=a|b, c=0.
  - op10: r=a^b^cin, c=a&b|(a^b)&cin.
  - op11: r=less (less=0 for all bits in RUN), c as op10.
  - Carry flop takes c each cycle.
- States:
  - IDLE: start_i=1 -> latch operands and ctrl, idx=0, carry=cin0, busy_o=1, go RUN.
  - RUN: one bit per edge into internal shift reg. On processing idx=WIDTH-1, compute:
    - cout = c of bit WIDTH-1
    - ovf = cin(WIDTH-1) ^ c(WIDTH-1) for ADD/SUB/SLT, else 0
    - set = sum(WIDTH-1) ^ ovf
    - Then go DONE.
  - DONE: result_o/flags registered on the DONE-entry edge.
    - SLT: result_o = {WIDTH-1 zeros, set}; cout_o/overflow_o report the underlying subtraction.
    - done_o=1 and busy_o=0 for exactly one cycle.
    - start_i=1 here is accepted (back-to-back, behaves as IDLE accept); otherwise go IDLE.
- Latency: start sampled at edge k -> done_o high in cycle after edge k+WIDTH. busy_o high from edge k to edge k+WIDTH.
- Output stability:
  - result_o/zero_o/cout_o/overflow_o change only on DONE entry or reset. No partial results visible.
  - zero_o is computed from the final result_o, including the SLT form.
- Input rules:
  - start_i while busy_o=1 is ignored (no queuing).
  - Operand/ctrl changes during RUN have no effect.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> done_o exactly 32 cycles after start edge; result 0x80000000, overflow 1, cout 0, zero 0.
- SUB 5 - 5 -> result 0, zero 1, cout 1, overflow 0. Back-to-back ADD 0xFFFFFFFF+1 issued in the DONE cycle -> result 0, cout 1, zero 1, done 32 cycles later.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 0x00000001. SLT 0x7FFFFFFF vs 0x80000000 -> result 0 (overflow-corrected), overflow 1.
- AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000. OR same -> 0xFFF0FFF0. NOR 0,0 -> 0xFFFFFFFF. All with cout 0, overflow 0. Invalid ctrl 1111 -> result 0.
- start_i pulsed and operands changed at cycles 5 and 10 of a RUN -> ignored; single done_o with original operands' result.
- rst_i asserted asynchronously mid-cycle at bit 17 -> all outputs 0 immediately, no done_o. A new ADD 3+4 after release -> 7.
